// File: rtl/aemb2_tmr_intc_pkg.sv
// Shared register map, CTRL bit positions and a byte-lane merge helper
// for the aeMB2 timer/interrupt block.
package aemb2_tmr_intc_pkg;

    // Word offsets (twb_adr_o[3:2])
    localparam logic [1:0] TMR_CTRL  = 2'd0;
    localparam logic [1:0] TMR_LOAD  = 2'd1;
    localparam logic [1:0] TMR_COUNT = 2'd2;
    localparam logic [1:0] TMR_STAT  = 2'd3;

    // CTRL bit positions
    localparam int TMR_EN      = 0;
    localparam int TMR_ARL     = 1;
    localparam int TMR_IE      = 2;
    localparam int TMR_PSC_LSB = 8;

    // Replace only the byte lanes selected by sel; keep the rest of old_v.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = sel[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/aemb2_tmr_psc.sv
// Prescaler: counts 0..psc while enabled and pulses tick on the last count.
module aemb2_tmr_psc #(
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);

    logic [PSC_W-1:0] cnt_q;
    logic [PSC_W-1:0] cnt_d;

    // Tick on the terminal count; >= keeps the period sane if PSC is
    // lowered below the running count while enabled.
    always_comb begin
        tick  = en && (cnt_q >= psc);
        cnt_d = cnt_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PSC_W'(1);
        end
    end

    // Prescaler count register, held at 0 while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aemb2_tmr_intc.sv
// Wishbone-slave timer: prescaled down-counter, sticky pending flag and a
// registered level interrupt for the CPU's sys_int_i.
module aemb2_tmr_intc
    import aemb2_tmr_intc_pkg::*;
#(
    parameter int PSC_W = 8,
    parameter int CNT_W = 32
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic [3:2]  twb_adr_o,
    input  logic [31:0] twb_dat_o,
    input  logic [3:0]  twb_sel_o,
    input  logic        twb_stb_o,
    input  logic        twb_cyc_o,
    input  logic        twb_wre_o,
    output logic [31:0] twb_dat_i,
    output logic        twb_ack_i,
    output logic        tmr_int_o
);

    logic             en_q, en_d;
    logic             arl_q, arl_d;
    logic             ie_q, ie_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [CNT_W-1:0] load_q, load_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pnd_q, pnd_d;
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic             int_q, int_d;

    logic             tick;
    logic             acc, wr, rd;
    logic             pnd_set, pnd_clr;
    logic [31:0]      ctrl_rd, load_rd, count_rd, stat_rd;
    logic [31:0]      ctrl_wr;

    aemb2_tmr_psc #(
        .PSC_W (PSC_W)
    ) u_psc (
        .clk  (sys_clk_i),
        .rst  (sys_rst_i),
        .en   (en_q),
        .psc  (psc_q),
        .tick (tick)
    );

    // Zero-extended register views used for reads and byte-lane merges.
    always_comb begin
        ctrl_rd                          = '0;
        ctrl_rd[TMR_EN]                  = en_q;
        ctrl_rd[TMR_ARL]                 = arl_q;
        ctrl_rd[TMR_IE]                  = ie_q;
        ctrl_rd[TMR_PSC_LSB +: PSC_W]    = psc_q;
        load_rd                          = 32'(load_q);
        count_rd                         = 32'(count_q);
        stat_rd                          = {31'd0, pnd_q};
    end

    // Counter/expiry first, then bus writes override so the write wins.
    always_comb begin
        acc     = twb_stb_o & twb_cyc_o & ~ack_q;
        wr      = acc & twb_wre_o;
        rd      = acc & ~twb_wre_o;
        en_d    = en_q;
        arl_d   = arl_q;
        ie_d    = ie_q;
        psc_d   = psc_q;
        load_d  = load_q;
        count_d = count_q;
        pnd_set = 1'b0;
        pnd_clr = 1'b0;
        ctrl_wr = merge_bytes(ctrl_rd, twb_dat_o, twb_sel_o);

        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                pnd_set = 1'b1;
                if (arl_q) begin
                    count_d = load_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end

        if (wr) begin
            case (twb_adr_o)
                TMR_CTRL: begin
                    if (twb_sel_o[0]) begin
                        en_d  = ctrl_wr[TMR_EN];
                        arl_d = ctrl_wr[TMR_ARL];
                        ie_d  = ctrl_wr[TMR_IE];
                    end
                    psc_d = ctrl_wr[TMR_PSC_LSB +: PSC_W];
                end
                TMR_LOAD:  load_d  = CNT_W'(merge_bytes(load_rd, twb_dat_o, twb_sel_o));
                TMR_COUNT: count_d = CNT_W'(merge_bytes(count_rd, twb_dat_o, twb_sel_o));
                default:   pnd_clr = twb_sel_o[0] & twb_dat_o[0];
            endcase
        end

        // A set in the same cycle as a clear leaves PND asserted.
        pnd_d = pnd_set | (pnd_q & ~pnd_clr);
        ack_d = acc;
        int_d = pnd_d & ie_d;

        dat_d = '0;
        if (rd) begin
            case (twb_adr_o)
                TMR_CTRL:  dat_d = ctrl_rd;
                TMR_LOAD:  dat_d = load_rd;
                TMR_COUNT: dat_d = count_rd;
                default:   dat_d = stat_rd;
            endcase
        end
    end

    // State, bus response and interrupt registers.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            en_q    <= 1'b0;
            arl_q   <= 1'b0;
            ie_q    <= 1'b0;
            psc_q   <= '0;
            load_q  <= '0;
            count_q <= '0;
            pnd_q   <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            int_q   <= 1'b0;
        end else begin
            en_q    <= en_d;
            arl_q   <= arl_d;
            ie_q    <= ie_d;
            psc_q   <= psc_d;
            load_q  <= load_d;
            count_q <= count_d;
            pnd_q   <= pnd_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            int_q   <= int_d;
        end
    end

    assign twb_ack_i = ack_q;
    assign twb_dat_i = dat_q;
    assign tmr_int_o = int_q;

endmodule
